// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage with a small tagged FIFO.
//
// Owns the fetch PC and drives the imem address from it. The imem read data is
// combinational from that address; each push captures {instr, pc, fault} into a
// DEPTH-entry FIFO. Decode pulls entries over a valid/ready handshake. A redirect
// flushes the queue and restarts fetch at the target. A faulting fetch (misaligned
// or beyond IMEM_TOP) queues a single fault entry and halts fetch until the next
// redirect or reset.
//
// Ports:
//   i_clk          clock, all state on rising edge
//   i_rst          synchronous active-high reset
//   o_imem_addr    fetch address to imem (the fetch PC register)
//   i_imem_instr   imem read data for o_imem_addr
//   i_redirect     redirect request from execute
//   i_redirect_pc  redirect target
//   o_valid        head entry valid
//   i_ready        decode accepts the head this cycle
//   o_instr        head instruction (0 when empty)
//   o_pc           head PC (0 when empty)
//   o_fault        head entry is a fetch fault (0 when empty)
//   o_count        current occupancy, 0..DEPTH

module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] IMEM_TOP = 32'h0000_1FFF
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    output logic [31:0]                o_imem_addr,
    input  logic [31:0]                i_imem_instr,
    input  logic                       i_redirect,
    input  logic [31:0]                i_redirect_pc,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [31:0]                o_instr,
    output logic [31:0]                o_pc,
    output logic                       o_fault,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int            AW   = $clog2(DEPTH);
    localparam int            CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Fetch state
    logic [31:0]   fetch_pc;
    logic          halted;

    // FIFO state
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];
    logic          mem_fault [DEPTH];

    logic          fetch_fault;
    logic          pop;
    logic          push;
    logic [31:0]   push_instr;

    assign o_imem_addr = fetch_pc;

    assign fetch_fault = (fetch_pc[1:0] != 2'b00) || (fetch_pc > IMEM_TOP);

    // A fault entry carries no instruction bits; decode must key off o_fault.
    assign push_instr = fetch_fault ? 32'h0000_0000 : i_imem_instr;

    assign o_valid = (count != '0);
    assign pop     = o_valid & i_ready;

    // When full, a same-cycle pop frees the slot being written, so fetch keeps
    // streaming at one instruction per cycle.
    assign push = !i_rst && !i_redirect && !halted && ((count < FULL) || pop);

    // Control state: reset beats redirect, redirect beats push/pop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc <= RESET_PC;
            halted   <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (i_redirect) begin
            // Full flush; any coincident pop is absorbed by the flush.
            fetch_pc <= i_redirect_pc;
            halted   <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                // A faulting fetch parks the PC on the bad address so the
                // imem address shows where fetch stopped.
                if (fetch_fault) begin
                    halted <= 1'b1;
                end else begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= push_instr;
            mem_pc[wr_ptr]    <= fetch_pc;
            mem_fault[wr_ptr] <= fetch_fault;
        end
    end

    // Head fields are forced to zero while empty so stale storage never leaks.
    always_comb begin
        o_instr = 32'h0000_0000;
        o_pc    = 32'h0000_0000;
        o_fault = 1'b0;
        if (o_valid) begin
            o_instr = mem_instr[rd_ptr];
            o_pc    = mem_pc[rd_ptr];
            o_fault = mem_fault[rd_ptr];
        end
    end

    assign o_count = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed stimulus with a scoreboard of expected
// handshaked entries, checked by an independent negedge monitor, plus direct
// checks of occupancy, fetch address and head fields at key points.

module tb_fetch_queue;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
    logic [2:0]  count;

    int     checks   = 0;
    int     failures = 0;
    entry_t exp_q[$];
    entry_t mon_e;

    always #5 clk = ~clk;

    // imem contents: three program words at 0x0/0x4/0x8, an address-derived
    // pattern elsewhere.
    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0004: return 32'h0010_0093;
            32'h0000_0008: return 32'h0020_0113;
            default:       return 32'hC0DE_0000 ^ a;
        endcase
    endfunction

    assign imem_instr = imem(imem_addr);

    fetch_queue #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4),
        .IMEM_TOP (32'h0000_1FFF)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_addr   (imem_addr),
        .i_imem_instr  (imem_instr),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_valid       (valid),
        .i_ready       (ready),
        .o_instr       (instr),
        .o_pc          (pc),
        .o_fault       (fault),
        .o_count       (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_entry(input logic [31:0] e_instr, input logic [31:0] e_pc, input logic e_fault);
        entry_t e;
        e.instr = e_instr;
        e.pc    = e_pc;
        e.fault = e_fault;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every handshake must match the next expected entry, in order.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected_pc", pc, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_pc", pc, mon_e.pc);
                chk("pop_instr", instr, mon_e.instr);
                chk("pop_fault", {31'd0, fault}, {31'd0, mon_e.fault});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        ready       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        tick(2);

        // Reset state
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        // Streaming from reset, one instruction per cycle
        expect_entry(32'h0000_0013, 32'h0, 1'b0);
        expect_entry(32'h0010_0093, 32'h4, 1'b0);
        expect_entry(32'h0020_0113, 32'h8, 1'b0);
        rst   = 1'b0;
        ready = 1'b1;
        tick();
        chk("first_valid", {31'd0, valid}, 32'd1);
        chk("first_pc", pc, 32'h0);
        chk("first_instr", instr, 32'h0000_0013);
        tick(3);
        ready = 1'b0;
        rst   = 1'b1;
        tick();

        // Backpressure: fill to DEPTH and hold
        rst = 1'b0;
        tick(10);
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_addr", imem_addr, 32'h10);
        chk("full_head_pc", pc, 32'h0);

        // Single pop while full: pop and push together
        expect_entry(32'h0000_0013, 32'h0, 1'b0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("pulse_count", {29'd0, count}, 32'd4);
        chk("pulse_head_pc", pc, 32'h4);
        chk("pulse_addr", imem_addr, 32'h14);

        // Drain in order, fetch continues with no gap or duplicate
        expect_entry(32'h0010_0093, 32'h4, 1'b0);
        expect_entry(32'h0020_0113, 32'h8, 1'b0);
        expect_entry(32'hC0DE_000C, 32'hC, 1'b0);
        expect_entry(32'hC0DE_0010, 32'h10, 1'b0);
        expect_entry(32'hC0DE_0014, 32'h14, 1'b0);
        expect_entry(32'hC0DE_0018, 32'h18, 1'b0);
        ready = 1'b1;
        tick(6);
        ready = 1'b0;
        chk("drain_head_pc", pc, 32'h1C);
        chk("drain_count", {29'd0, count}, 32'd4);

        // Redirect with 3 entries queued
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(3);
        chk("pre_redir_count", {29'd0, count}, 32'd3);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("redir_valid", {31'd0, valid}, 32'd0);
        chk("redir_count", {29'd0, count}, 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        tick();
        chk("redir_new_valid", {31'd0, valid}, 32'd1);
        chk("redir_new_pc", pc, 32'h100);
        chk("redir_new_instr", instr, 32'hC0DE_0100);
        chk("redir_new_count", {29'd0, count}, 32'd1);

        // Fetch runs off the end of imem: one good entry, one fault, then halt
        redirect    = 1'b1;
        redirect_pc = 32'h1FFC;
        tick();
        redirect = 1'b0;
        ready    = 1'b1;
        expect_entry(32'hC0DE_1FFC, 32'h1FFC, 1'b0);
        expect_entry(32'h0000_0000, 32'h2000, 1'b1);
        tick(5);
        chk("halt_count", {29'd0, count}, 32'd0);
        chk("halt_valid", {31'd0, valid}, 32'd0);
        chk("halt_addr", imem_addr, 32'h2000);

        // Redirect clears halt and fetch resumes
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        expect_entry(32'h0000_0013, 32'h0, 1'b0);
        expect_entry(32'h0010_0093, 32'h4, 1'b0);
        tick(3);
        ready = 1'b0;
        chk("resume_head_pc", pc, 32'h8);
        chk("resume_count", {29'd0, count}, 32'd1);

        // Reset dominates a coincident redirect
        tick(2);
        chk("pre_rst_count", {29'd0, count}, 32'd3);
        rst         = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        chk("rst_redir_valid", {31'd0, valid}, 32'd0);
        chk("rst_redir_count", {29'd0, count}, 32'd0);
        chk("rst_redir_addr", imem_addr, 32'h0);
        rst      = 1'b0;
        redirect = 1'b0;

        // Misaligned redirect target yields a single fault entry
        redirect    = 1'b1;
        redirect_pc = 32'h6;
        ready       = 1'b1;
        tick();
        redirect = 1'b0;
        expect_entry(32'h0000_0000, 32'h6, 1'b1);
        tick(4);
        ready = 1'b0;
        chk("misal_count", {29'd0, count}, 32'd0);
        chk("misal_addr", imem_addr, 32'h6);

        tick(2);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage sitting directly upstream of the instruction memory (imem) and directly downstream of nothing but the redirect source.
- Owns the fetch PC and drives the imem address.
- Captures the combinational imem read data into a small FIFO, tagged with its PC and a fault flag.
- Presents entries to decode over a valid/ready handshake; supports branch/jump redirect with full flush.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- DEPTH, 4, FIFO entries (power of 2, >= 2).
- IMEM_TOP, 32'h0000_1FFF, highest valid byte address of imem.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- o_imem_addr  out  32  fetch address to imem (combinational from fetch PC register).
- i_imem_instr  in  32  imem read data, combinational from o_imem_addr.
- i_redirect  in  1  redirect request (taken branch/jump) from execute.
- i_redirect_pc  in  32  redirect target.
- o_valid  out  1  head entry valid.
- i_ready  in  1  decode accepts head this cycle.
- o_instr  out  32  head instruction.
- o_pc  out  32  head PC.
- o_fault  out  1  head entry is a fetch fault (misaligned or out of range).
- o_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (i_rst=1 at edge): fetch_pc<=RESET_PC, count<=0, rd/wr ptr<=0, halted<=0.
- Reset outputs: o_valid=0, o_count=0, o_instr=0, o_pc=0, o_fault=0. Head fields read 0 whenever count==0.
- Reset dominates redirect, push and pop.
- o_imem_addr = fetch_pc at all times, including reset and halt.
- pop = o_valid & i_ready. Consumer may hold i_ready high with o_valid low with no effect.
- Push condition: !i_rst & !i_redirect & !halted & (count<DEPTH | pop).
- Full with simultaneous pop: push is allowed and count stays DEPTH.
- On push:
  - Write {i_imem_instr, fetch_pc, fault} at wr_ptr; fetch_pc<=fetch_pc+4 (32-bit wrap).
- Fault: fetch_pc[1:0]!=2'b00 or fetch_pc>IMEM_TOP.
  - Faulting push stores instr=32'h0000_0000 and fault=1.
  - Faulting push sets halted<=1 and does not advance fetch_pc.
  - Halted stays set until redirect or reset; only one fault entry is ever queued.
- Latency: a push at edge N makes the entry visible at the head after edge N when the queue was empty. First instruction after reset release: o_valid=1 one cycle after the first non-reset edge.
- Throughput: 1 instr/cycle sustained when i_ready=1 continuously.
- Redirect (i_redirect=1, no reset):
  - count<=0, ptrs<=0, halted<=0, fetch_pc<=i_redirect_pc.
  - No push that cycle. A coincident pop is still counted as a handshake by decode, but the queue flushes regardless.
  - Next cycle o_valid=0; the following edge pushes mem[i_redirect_pc].
  - Misaligned redirect target produces a fault entry on that next push.
- Count update otherwise: count <= count + push - pop. Never exceeds DEPTH, never underflows.
- Pointers wrap modulo DEPTH.
- Head outputs are read from the registered FIFO; no combinational path from i_imem_instr to o_instr.

Test Plan:
- Reset then i_ready=1 with imem words 0x00000013, 0x00100093, 0x00200113 at 0x0, 0x4, 0x8 -> o_valid rises one cycle after reset release; o_pc sequence 0x0, 0x4, 0x8 with matching o_instr, one per cycle; o_fault=0.
- i_ready=0 for 10 cycles -> o_count climbs to 4 and holds; o_imem_addr stops at 0x10. Then i_ready=1 -> entries drain in order 0x0..0xC and fetch resumes at 0x10 with no gap or duplicate.
- At count=4, pulse i_ready=1 for one cycle -> pop and push together, o_count stays 4, new tail pc=0x10.
- With 3 entries queued, assert i_redirect with i_redirect_pc=0x100 -> next cycle o_valid=0, o_count=0; the cycle after, o_pc=0x100.
- Redirect to 0x1FFC, i_ready=1 -> entry pc=0x1FFC fault=0, then pc=0x2000 fault=1 instr=0. No further entries; o_imem_addr holds at 0x2000 until a redirect to 0x0 resumes normal fetch.
- Assert i_rst mid-stream with count=3 and i_redirect=1 -> after the edge o_valid=0, o_count=0, o_imem_addr=RESET_PC, not 0x100.
